// File: rtl/rhd2048_spi_master.sv
// SPI master for 32 Intan RHD chips on a shared SCLK/MOSI/CS bus. Runs the config, record and
// impedance-check sequences, deskews every MISO line and streams the captured words.
module rhd2048_spi_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        config_start,
  input  logic        record_start,
  input  logic        zcheck_start,
  input  logic [7:0]  oversample_offset_A1, oversample_offset_A2,
  input  logic [7:0]  oversample_offset_B1, oversample_offset_B2,
  input  logic [7:0]  oversample_offset_C1, oversample_offset_C2,
  input  logic [7:0]  oversample_offset_D1, oversample_offset_D2,
  input  logic [7:0]  oversample_offset_E1, oversample_offset_E2,
  input  logic [7:0]  oversample_offset_F1, oversample_offset_F2,
  input  logic [7:0]  oversample_offset_G1, oversample_offset_G2,
  input  logic [7:0]  oversample_offset_H1, oversample_offset_H2,
  input  logic [7:0]  oversample_offset_I1, oversample_offset_I2,
  input  logic [7:0]  oversample_offset_J1, oversample_offset_J2,
  input  logic [7:0]  oversample_offset_K1, oversample_offset_K2,
  input  logic [7:0]  oversample_offset_L1, oversample_offset_L2,
  input  logic [7:0]  oversample_offset_M1, oversample_offset_M2,
  input  logic [7:0]  oversample_offset_N1, oversample_offset_N2,
  input  logic [7:0]  oversample_offset_O1, oversample_offset_O2,
  input  logic [7:0]  oversample_offset_P1, oversample_offset_P2,
  input  logic        MISO1_A, MISO2_A, MISO1_B, MISO2_B, MISO1_C, MISO2_C, MISO1_D, MISO2_D,
  input  logic        MISO1_E, MISO2_E, MISO1_F, MISO2_F, MISO1_G, MISO2_G, MISO1_H, MISO2_H,
  input  logic        MISO1_I, MISO2_I, MISO1_J, MISO2_J, MISO1_K, MISO2_K, MISO1_L, MISO2_L,
  input  logic        MISO1_M, MISO2_M, MISO1_N, MISO2_N, MISO1_O, MISO2_O, MISO1_P, MISO2_P,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS,
  output logic [7:0]  channel_out,
  output logic        result_valid,
  output logic [4:0]  result_chip,
  output logic [15:0] result_data
);

  typedef enum logic [1:0] {StIdle, StConfig, StRecord, StZcheck} state_e;

  state_e      state_q, state_d;
  logic [7:0]  f_q, f_d;
  logic [7:0]  seq_q, seq_d;
  logic [2:0]  pend_q, pend_d, pend_eff;  // {config, zcheck, record}
  logic        stream_q, stream_d;
  logic        frame_end, active_q;
  logic [2:0]  req;
  logic [31:0] miso;
  logic [7:0]  offset [32];
  logic [15:0] cap_q [32];
  logic [15:0] cap_d [32];
  logic [15:0] bank_q [32];
  logic [15:0] bank_d [32];

  // Chip index is {port, n-1}: bit 0 is A1, bit 1 is A2, bit 2 is B1 ...
  assign miso = {MISO2_P, MISO1_P, MISO2_O, MISO1_O, MISO2_N, MISO1_N, MISO2_M, MISO1_M,
                 MISO2_L, MISO1_L, MISO2_K, MISO1_K, MISO2_J, MISO1_J, MISO2_I, MISO1_I,
                 MISO2_H, MISO1_H, MISO2_G, MISO1_G, MISO2_F, MISO1_F, MISO2_E, MISO1_E,
                 MISO2_D, MISO1_D, MISO2_C, MISO1_C, MISO2_B, MISO1_B, MISO2_A, MISO1_A};

  assign offset = '{oversample_offset_A1, oversample_offset_A2, oversample_offset_B1,
                    oversample_offset_B2, oversample_offset_C1, oversample_offset_C2,
                    oversample_offset_D1, oversample_offset_D2, oversample_offset_E1,
                    oversample_offset_E2, oversample_offset_F1, oversample_offset_F2,
                    oversample_offset_G1, oversample_offset_G2, oversample_offset_H1,
                    oversample_offset_H2, oversample_offset_I1, oversample_offset_I2,
                    oversample_offset_J1, oversample_offset_J2, oversample_offset_K1,
                    oversample_offset_K2, oversample_offset_L1, oversample_offset_L2,
                    oversample_offset_M1, oversample_offset_M2, oversample_offset_N1,
                    oversample_offset_N2, oversample_offset_O1, oversample_offset_O2,
                    oversample_offset_P1, oversample_offset_P2};

  function automatic logic [7:0] config_reg(input logic [4:0] r);
    case (r)
      5'd0:  config_reg = 8'hDE;
      5'd1:  config_reg = 8'h20;
      5'd2:  config_reg = 8'h28;
      5'd3:  config_reg = 8'h02;
      5'd4:  config_reg = 8'hD6;
      5'd8:  config_reg = 8'h16;
      5'd9:  config_reg = 8'h17;
      5'd10: config_reg = 8'hA8;
      5'd11: config_reg = 8'h0A;
      5'd12, 5'd13, 5'd14, 5'd15: config_reg = 8'hFF;
      default: config_reg = 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] frame_cmd(input state_e st, input logic [7:0] seq);
    frame_cmd = 16'h0000;
    unique case (st)
      StConfig: begin
        if (seq < 8'd3)       frame_cmd = 16'hFF00;
        else if (seq < 8'd21) frame_cmd = {2'b10, 6'(seq - 8'd3), config_reg(5'(seq - 8'd3))};
        else if (seq == 8'd21) frame_cmd = 16'h5500;
        else                  frame_cmd = 16'hE800;
      end
      StRecord: frame_cmd = {2'b00, seq[5:0], 8'h00};
      StZcheck: begin
        if (seq == 8'd0)        frame_cmd = 16'h8501;
        else if (seq == 8'd129) frame_cmd = 16'h8500;
        else if (seq[0])        frame_cmd = {10'b10_0001_11_00, 6'((seq - 8'd1) >> 1)};
        else                    frame_cmd = {2'b00, 6'((seq - 8'd1) >> 1), 8'h00};
      end
      default: frame_cmd = 16'h0000;
    endcase
  endfunction

  // Record reports two frames behind the command because of the chip's conversion pipeline.
  function automatic logic [7:0] frame_channel(input state_e st, input logic [7:0] seq);
    frame_channel = 8'h00;
    unique case (st)
      StRecord: frame_channel = {2'b00, seq[5:0] - 6'd2};
      StZcheck: begin
        if (seq != 8'd0 && seq != 8'd129) frame_channel = {2'b00, 6'((seq - 8'd1) >> 1)};
      end
      default: frame_channel = 8'h00;
    endcase
  endfunction

  // Returns {cs, sclk, mosi} for frame position f.
  function automatic logic [2:0] bus_bits(input logic [7:0] f, input logic [15:0] cmd,
                                          input logic active);
    logic [3:0] k;
    k = 4'((f - 8'd4) >> 3);
    bus_bits = 3'b100;
    if (active) begin
      bus_bits[2] = f > 8'd135;
      bus_bits[1] = (f >= 8'd8) && (f <= 8'd131) && !f[2];
      bus_bits[0] = (f >= 8'd4) && (f <= 8'd131) && cmd[4'd15 - k];
    end
  endfunction

  function automatic logic sample_hit(input logic [7:0] f, input logic [7:0] off);
    logic [7:0] first;
    logic [7:0] delta;
    first = 8'd8 + ((off > 8'd31) ? 8'd31 : off);
    delta = f - first;
    sample_hit = (f >= first) && (delta <= 8'd120) && (delta[2:0] == 3'd0);
  endfunction

  assign frame_end = (f_q == 8'd159);
  assign active_q  = (state_q != StIdle);
  assign req       = {config_start, zcheck_start, record_start};

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    pend_d   = pend_q;
    pend_eff = 3'b000;
    f_d      = frame_end ? 8'd0 : f_q + 8'd1;
    stream_d = frame_end ? active_q : stream_q;
    unique case (state_q)
      StIdle: begin
        pend_eff = pend_q | req;
        pend_d   = pend_eff;
        if (frame_end && (|pend_eff)) begin
          pend_d  = 3'b000;
          seq_d   = 8'd0;
          state_d = pend_eff[2] ? StConfig : (pend_eff[1] ? StZcheck : StRecord);
        end
      end
      StRecord: begin
        pend_eff = pend_q | {req[2:1], 1'b0};
        pend_d   = pend_eff;
        if (frame_end) begin
          seq_d = {2'b00, seq_q[5:0] + 6'd1};
          // Leave only once the full channel sweep has been issued.
          if ((seq_q[5:0] == 6'd63) && (|pend_eff[2:1])) begin
            pend_d  = 3'b000;
            seq_d   = 8'd0;
            state_d = pend_eff[2] ? StConfig : StZcheck;
          end
        end
      end
      StConfig: begin
        pend_d = 3'b000;
        if (frame_end) begin
          seq_d   = (seq_q == 8'd30) ? 8'd0 : seq_q + 8'd1;
          state_d = (seq_q == 8'd30) ? StIdle : StConfig;
        end
      end
      StZcheck: begin
        pend_d = 3'b000;
        if (frame_end) begin
          seq_d   = (seq_q == 8'd129) ? 8'd0 : seq_q + 8'd1;
          state_d = (seq_q == 8'd129) ? StIdle : StZcheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 32; j++) begin
      cap_d[j]  = cap_q[j];
      bank_d[j] = bank_q[j];
      if (active_q && sample_hit(f_q, offset[j])) cap_d[j] = {cap_q[j][14:0], miso[j]};
      // The last possible sample lands on f=159, so the bank takes the post-shift value.
      if (active_q && frame_end) bank_d[j] = cap_d[j];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      f_q          <= 8'd0;
      seq_q        <= 8'd0;
      pend_q       <= 3'b000;
      stream_q     <= 1'b0;
      for (int j = 0; j < 32; j++) begin
        cap_q[j]  <= 16'h0000;
        bank_q[j] <= 16'h0000;
      end
      CS           <= 1'b1;
      SCLK         <= 1'b0;
      MOSI         <= 1'b0;
      channel_out  <= 8'h00;
      result_valid <= 1'b0;
      result_chip  <= 5'd0;
      result_data  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      seq_q    <= seq_d;
      pend_q   <= pend_d;
      stream_q <= stream_d;
      for (int j = 0; j < 32; j++) begin
        cap_q[j]  <= cap_d[j];
        bank_q[j] <= bank_d[j];
      end
      {CS, SCLK, MOSI} <= bus_bits(f_d, frame_cmd(state_d, seq_d), state_d != StIdle);
      channel_out      <= frame_channel(state_d, seq_d);
      result_valid     <= stream_d && (f_d < 8'd32);
      result_chip      <= (stream_d && (f_d < 8'd32)) ? f_d[4:0] : 5'd0;
      result_data      <= (stream_d && (f_d < 8'd32)) ? bank_d[f_d[4:0]] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_rhd2048_spi_master.sv
// Directed-sequence bench with randomized slave payloads and MISO delays, checked against a
// frame-level model of the bus, the command lists and the per-chip sampling rule.
module tb_rhd2048_spi_master;

  logic        clk, rstn;
  logic        config_start, record_start, zcheck_start;
  logic [7:0]  offs [32];
  logic [31:0] miso;
  logic        SCLK, MOSI, CS;
  logic [7:0]  channel_out;
  logic        result_valid;
  logic [4:0]  result_chip;
  logic [15:0] result_data;

  int          vectors, miscompares;
  logic [15:0] tx [32];
  int          dly [32];
  logic [15:0] exp_bank [32];
  logic        stream_exp;
  logic [7:0]  cfg_regs [18] = '{8'hDE, 8'h20, 8'h28, 8'h02, 8'hD6, 8'h00, 8'h00, 8'h00, 8'h16,
                                 8'h17, 8'hA8, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [15:0] zq_cmd [$];
  logic [7:0]  zq_ch [$];

  rhd2048_spi_master dut (
    .clk(clk), .rstn(rstn),
    .config_start(config_start), .record_start(record_start), .zcheck_start(zcheck_start),
    .oversample_offset_A1(offs[0]),  .oversample_offset_A2(offs[1]),
    .oversample_offset_B1(offs[2]),  .oversample_offset_B2(offs[3]),
    .oversample_offset_C1(offs[4]),  .oversample_offset_C2(offs[5]),
    .oversample_offset_D1(offs[6]),  .oversample_offset_D2(offs[7]),
    .oversample_offset_E1(offs[8]),  .oversample_offset_E2(offs[9]),
    .oversample_offset_F1(offs[10]), .oversample_offset_F2(offs[11]),
    .oversample_offset_G1(offs[12]), .oversample_offset_G2(offs[13]),
    .oversample_offset_H1(offs[14]), .oversample_offset_H2(offs[15]),
    .oversample_offset_I1(offs[16]), .oversample_offset_I2(offs[17]),
    .oversample_offset_J1(offs[18]), .oversample_offset_J2(offs[19]),
    .oversample_offset_K1(offs[20]), .oversample_offset_K2(offs[21]),
    .oversample_offset_L1(offs[22]), .oversample_offset_L2(offs[23]),
    .oversample_offset_M1(offs[24]), .oversample_offset_M2(offs[25]),
    .oversample_offset_N1(offs[26]), .oversample_offset_N2(offs[27]),
    .oversample_offset_O1(offs[28]), .oversample_offset_O2(offs[29]),
    .oversample_offset_P1(offs[30]), .oversample_offset_P2(offs[31]),
    .MISO1_A(miso[0]),  .MISO2_A(miso[1]),  .MISO1_B(miso[2]),  .MISO2_B(miso[3]),
    .MISO1_C(miso[4]),  .MISO2_C(miso[5]),  .MISO1_D(miso[6]),  .MISO2_D(miso[7]),
    .MISO1_E(miso[8]),  .MISO2_E(miso[9]),  .MISO1_F(miso[10]), .MISO2_F(miso[11]),
    .MISO1_G(miso[12]), .MISO2_G(miso[13]), .MISO1_H(miso[14]), .MISO2_H(miso[15]),
    .MISO1_I(miso[16]), .MISO2_I(miso[17]), .MISO1_J(miso[18]), .MISO2_J(miso[19]),
    .MISO1_K(miso[20]), .MISO2_K(miso[21]), .MISO1_L(miso[22]), .MISO2_L(miso[23]),
    .MISO1_M(miso[24]), .MISO2_M(miso[25]), .MISO1_N(miso[26]), .MISO2_N(miso[27]),
    .MISO1_O(miso[28]), .MISO2_O(miso[29]), .MISO1_P(miso[30]), .MISO2_P(miso[31]),
    .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .channel_out(channel_out), .result_valid(result_valid),
    .result_chip(result_chip), .result_data(result_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave j shifts bit 15-k out dly[j] cycles after the k-th SCLK rise and holds the last bit.
  function automatic logic slave_bit(input int j, input int f);
    int k;
    if (f < 8 + dly[j]) return 1'b0;
    k = (f - 8 - dly[j]) / 8;
    if (k > 15) k = 15;
    return tx[j][15 - k];
  endfunction

  function automatic logic [15:0] cfg_word(input int s);
    if (s < 3) return 16'hFF00;
    if (s < 21) return {2'b10, 6'(s - 3), cfg_regs[s - 3]};
    if (s == 21) return 16'h5500;
    return 16'hE800;
  endfunction

  // Runs one 160-cycle frame starting at the negedge of f=0.
  task automatic do_frame(input logic act, input logic [15:0] exp_cmd, input logic [7:0] exp_chan,
                          input logic [2:0] pulse);
    logic [15:0] got;
    logic [15:0] nxt;
    logic        sclk_prev;
    int          rises, cs_low, s, off;
    got = 16'h0; rises = 0; cs_low = 0; sclk_prev = 1'b0;
    for (int j = 0; j < 32; j++) tx[j] = 16'($urandom);
    tx[0] = {8'h00, exp_chan};
    tx[1] = 16'(exp_chan) + 16'd64;
    tx[2] = 16'hA5C3;
    tx[3] = 16'hA5C3;
    check("channel_out", channel_out, exp_chan);
    for (int f = 0; f < 160; f++) begin
      for (int j = 0; j < 32; j++) miso[j] = slave_bit(j, f);
      if (f == 10) {config_start, zcheck_start, record_start} = pulse;
      if (f == 11) {config_start, zcheck_start, record_start} = 3'b000;
      if (!CS) cs_low++;
      if (SCLK && !sclk_prev) begin
        got = {got[14:0], MOSI};
        rises++;
      end
      sclk_prev = SCLK;
      if (stream_exp && f < 32) begin
        check("result_valid", result_valid, 1);
        check("result_chip", result_chip, f);
        check("result_data", result_data, exp_bank[f]);
        if (f == 2) check("deskew_off1", result_data, 16'hA5C3);
        if (f == 3) check("deskew_off0", result_data, 16'h52E1);
      end else if (f < 40) begin
        check("result_valid_low", result_valid, 0);
      end
      @(negedge clk);
    end
    if (act) check("mosi_word", got, exp_cmd);
    check("sclk_rises", rises, act ? 16 : 0);
    check("cs_low_cycles", cs_low, act ? 136 : 0);
    if (act) begin
      for (int j = 0; j < 32; j++) begin
        off = (offs[j] > 8'd31) ? 31 : int'(offs[j]);
        nxt = 16'h0;
        for (int k = 0; k < 16; k++) begin
          s = 8 + 8 * k + off;
          nxt[15 - k] = slave_bit(j, s);
        end
        exp_bank[j] = nxt;
      end
    end
    stream_exp = act;
  endtask

  task automatic start_and_wait(input logic [2:0] r);
    int n;
    {config_start, zcheck_start, record_start} = r;
    @(negedge clk);
    {config_start, zcheck_start, record_start} = 3'b000;
    n = 0;
    while (CS !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cs_fall_in_time", CS, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; stream_exp = 1'b0;
    rstn = 1'b0; miso = 32'h0;
    {config_start, zcheck_start, record_start} = 3'b000;
    for (int j = 0; j < 32; j++) begin
      dly[j]  = $urandom_range(0, 20);
      offs[j] = 8'(dly[j] + $urandom_range(0, 7));
      exp_bank[j] = 16'h0;
    end
    dly[2] = 1;  offs[2] = 8'd1;
    dly[3] = 1;  offs[3] = 8'd0;
    dly[4] = 28; offs[4] = 8'd200;
    dly[5] = 24; offs[5] = 8'd31;
    dly[6] = 31; offs[6] = 8'd255;
    zq_cmd.push_back(16'h8501); zq_ch.push_back(8'd0);
    for (int c = 0; c < 64; c++) begin
      zq_cmd.push_back({8'h87, 8'(c)});     zq_ch.push_back(8'(c));
      zq_cmd.push_back({2'b00, 6'(c), 8'h00}); zq_ch.push_back(8'(c));
    end
    zq_cmd.push_back(16'h8500); zq_ch.push_back(8'd0);

    repeat (3) @(negedge clk);
    check("rst_cs", CS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_channel", channel_out, 0);
    check("rst_valid", result_valid, 0);
    check("rst_chip", result_chip, 0);
    check("rst_data", result_data, 0);
    rstn = 1'b1;

    // Record sweep with a zcheck request latched mid-sweep.
    start_and_wait(3'b001);
    for (int s = 0; s < 64; s++)
      do_frame(1'b1, {2'b00, 6'(s), 8'h00}, 8'((s + 62) % 64), (s == 5) ? 3'b010 : 3'b000);
    for (int s = 0; s < 130; s++) do_frame(1'b1, zq_cmd[s], zq_ch[s], 3'b000);
    do_frame(1'b0, 16'h0, 8'd0, 3'b000);
    // All three requests at once: config has priority; a record request during config is dropped.
    do_frame(1'b0, 16'h0, 8'd0, 3'b111);
    for (int s = 0; s < 31; s++) do_frame(1'b1, cfg_word(s), 8'd0, (s == 5) ? 3'b001 : 3'b000);
    do_frame(1'b0, 16'h0, 8'd0, 3'b000);
    do_frame(1'b0, 16'h0, 8'd0, 3'b000);

    // Mid-frame asynchronous reset.
    start_and_wait(3'b001);
    do_frame(1'b1, 16'h0000, 8'd62, 3'b000);
    do_frame(1'b1, 16'h0100, 8'd63, 3'b000);
    repeat (25) @(negedge clk);
    check("pre_rst_sclk", SCLK, 1);
    check("pre_rst_valid", result_valid, 1);
    check("pre_rst_chip", result_chip, 25);
    rstn = 1'b0;
    #1;
    check("async_rst_cs", CS, 1);
    check("async_rst_sclk", SCLK, 0);
    check("async_rst_valid", result_valid, 0);
    check("async_rst_mosi", MOSI, 0);
    @(negedge clk);
    rstn = 1'b1;
    stream_exp = 1'b0;
    start_and_wait(3'b001);
    do_frame(1'b1, 16'h0000, 8'd62, 3'b000);
    do_frame(1'b1, 16'h0100, 8'd63, 3'b000);
    do_frame(1'b1, 16'h0200, 8'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
